// File: rtl/fht_input_loader.sv
// fht_input_loader: streams signed ADC samples into the 4-bank FHT core
// write port, pulses the core start once a full frame is loaded, then waits
// for the core ready to fall and rise again before opening the next frame.
// Build option FHT_LOADER_BITREV_EN: samples are written in bit-reversed
// index order (core sees bit-reversed input); undefined gives natural order.
module fht_input_loader #(
  parameter int unsigned DW    = 16,
  parameter int unsigned N_BIT = 10,
  parameter int unsigned A_BIT = 8
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iVALID,
  input  logic signed [DW-1:0] iDATA,
  output logic                 oREADY,
  input  logic                 iABORT,
  input  logic                 iFHT_RDY,
  output logic signed [DW-1:0] oDATA,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic                 oWE_0,
  output logic                 oWE_1,
  output logic                 oWE_2,
  output logic                 oWE_3,
  output logic                 oSTART,
  output logic                 oBUSY,
  output logic                 oFRAME_DONE,
  output logic [7:0]           oFRAME_CNT
);

  localparam int unsigned NB = 4;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [N_BIT-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    data_q, data_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic [NB-1:0]    we_q, we_d;
  logic             start_q, start_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    fcnt_q, fcnt_d;

  logic             accept;
  logic [N_BIT-1:0] idx;
  logic [BW-1:0]    bank;

`ifdef FHT_LOADER_BITREV_EN
  // Reverse the sample counter so the core receives bit-reversed order.
  function automatic logic [N_BIT-1:0] bit_rev(input logic [N_BIT-1:0] v);
    logic [N_BIT-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_BIT; i++) begin
      r[i] = v[N_BIT-1-i];
    end
    return r;
  endfunction

  assign idx = bit_rev(cnt_q);
`else
  assign idx = cnt_q;
`endif

  // Top two index bits pick the bank, the rest is the in-bank address.
  assign bank   = idx[N_BIT-1 -: BW];
  assign accept = iVALID & ready_q;

  // Next-state and next-output computation; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = '0;
    start_d = 1'b0;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;

    case (state_q)
      S_IDLE: begin
        if (iFHT_RDY) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_d   = NB'(1) << bank;
          addr_d = idx[A_BIT-1:0];
          data_d = iDATA;
          cnt_d  = cnt_q + N_BIT'(1);
          if (cnt_q == '1) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!iFHT_RDY) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (iFHT_RDY) begin
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + CW'(1);
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (iABORT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      data_d  = data_q;
      addr_d  = addr_q;
      we_d    = '0;
      start_d = 1'b0;
      done_d  = 1'b0;
      fcnt_d  = fcnt_q;
    end

    // Decoded from the next state so the flops track the state exactly.
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      start_q <= start_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign oREADY      = ready_q;
  assign oDATA       = data_q;
  assign oADDR_WR    = addr_q;
  assign oWE_0       = we_q[0];
  assign oWE_1       = we_q[1];
  assign oWE_2       = we_q[2];
  assign oWE_3       = we_q[3];
  assign oSTART      = start_q;
  assign oBUSY       = busy_q;
  assign oFRAME_DONE = done_q;
  assign oFRAME_CNT  = fcnt_q;

endmodule
